// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare predictor table.
//   - cnt_t        : default-width saturating counter
//   - state_e      : table state (init sweep / ready)
//   - hash_idx     : gshare index hash (caller zero-extends and truncates)
//   - sat_update   : saturating counter step, width given by caller
package gshare_pkg;

  localparam int unsigned CNT_BITS_DEF = 2;
  localparam int unsigned HASH_W       = 32;
  localparam int unsigned SAT_W        = 16;

  typedef logic [CNT_BITS_DEF-1:0] cnt_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // addr XOR zero-extended history; callers cast operands to HASH_W
  function automatic logic [HASH_W-1:0] hash_idx(input logic [HASH_W-1:0] addr,
                                                 input logic [HASH_W-1:0] hist);
    return addr ^ hist;
  endfunction

  // Saturating increment/decrement of a 'bits'-wide counter held in SAT_W bits
  function automatic logic [SAT_W-1:0] sat_update(input logic [SAT_W-1:0] cnt,
                                                  input logic             taken,
                                                  input int unsigned      bits);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << bits) - SAT_W'(1);
    if (taken) begin
      return (cnt == max_val) ? cnt : cnt + SAT_W'(1);
    end
    return (cnt == '0) ? cnt : cnt - SAT_W'(1);
  endfunction

endpackage

// File: rtl/gshare_predictor_table_if.sv
// Bus between fetch / branch resolution (master) and the predictor table (slave).
//   pred*    : per-lane prediction request and registered response
//   spec*    : speculative GHR shift
//   recover* : GHR restore after mispredict
//   upd*     : counter training
//   OUT_ready: init sweep complete
interface gshare_predictor_table_if #(
  parameter int unsigned INDEX_LEN = 8,
  parameter int unsigned HIST_LEN  = 8,
  parameter int unsigned NUM_PORTS = 2
);

  logic                           OUT_ready;
  logic                           IN_predEn;
  logic [NUM_PORTS*INDEX_LEN-1:0] IN_predAddr;
  logic                           OUT_predValid;
  logic [NUM_PORTS-1:0]           OUT_predTaken;
  logic [HIST_LEN-1:0]            OUT_predHist;
  logic                           IN_specEn;
  logic                           IN_specTaken;
  logic                           IN_recoverEn;
  logic [HIST_LEN-1:0]            IN_recoverHist;
  logic                           IN_updEn;
  logic [INDEX_LEN-1:0]           IN_updAddr;
  logic [HIST_LEN-1:0]            IN_updHist;
  logic                           IN_updTaken;

  modport master (
    input  OUT_ready, OUT_predValid, OUT_predTaken, OUT_predHist,
    output IN_predEn, IN_predAddr, IN_specEn, IN_specTaken,
           IN_recoverEn, IN_recoverHist, IN_updEn, IN_updAddr,
           IN_updHist, IN_updTaken
  );

  modport slave (
    output OUT_ready, OUT_predValid, OUT_predTaken, OUT_predHist,
    input  IN_predEn, IN_predAddr, IN_specEn, IN_specTaken,
           IN_recoverEn, IN_recoverHist, IN_updEn, IN_updAddr,
           IN_updHist, IN_updTaken
  );

endinterface

// File: rtl/gshare_counter_array.sv
// Flop-based counter storage.
//   rd_addr/rd_data : NUM_PORTS asynchronous read ports
//   wr_*            : one write port; wr_rdata returns the current value at
//                     wr_addr so the caller can do a read-modify-write
// Storage has no reset: the owner initialises it with a sweep.
module gshare_counter_array #(
  parameter int unsigned INDEX_LEN = 8,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic [INDEX_LEN-1:0] rd_addr [NUM_PORTS],
  output logic [CNT_BITS-1:0]  rd_data [NUM_PORTS],
  input  logic                 wr_en,
  input  logic [INDEX_LEN-1:0] wr_addr,
  input  logic [CNT_BITS-1:0]  wr_data,
  output logic [CNT_BITS-1:0]  wr_rdata
);

  localparam int unsigned NUM_COUNTERS = 1 << INDEX_LEN;

  logic [CNT_BITS-1:0] mem_q [NUM_COUNTERS];

  // Single write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Asynchronous reads
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      rd_data[k] = mem_q[rd_addr[k]];
    end
  end

  assign wr_rdata = mem_q[wr_addr];

endmodule

// File: rtl/gshare_predictor_table.sv
// gshare predictor table: per-lane counters indexed by PC bits XOR GHR,
// registered prediction outputs, speculative GHR with recovery, and a
// hardware init sweep writing INIT_VAL to every counter after reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of gshare_predictor_table_if (predict/spec/recover/update)
module gshare_predictor_table
  import gshare_pkg::*;
#(
  parameter int unsigned INDEX_LEN = 8,
  parameter int unsigned HIST_LEN  = 8,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned NUM_PORTS = 2,
  parameter logic [CNT_BITS-1:0] INIT_VAL = CNT_BITS'(1) << (CNT_BITS - 1)
) (
  input logic clk,
  input logic rst,
  gshare_predictor_table_if.slave bus
);

  localparam int unsigned NUM_COUNTERS = 1 << INDEX_LEN;
  localparam logic [INDEX_LEN-1:0] LAST_IDX = INDEX_LEN'(NUM_COUNTERS - 1);

  state_e               state_q, state_d;
  logic [INDEX_LEN-1:0] ptr_q, ptr_d;
  logic [HIST_LEN-1:0]  ghr_q, ghr_d;
  logic                 ready_q, ready_d;
  logic                 pred_valid_q, pred_valid_d;
  logic [NUM_PORTS-1:0] pred_taken_q, pred_taken_d;
  logic [HIST_LEN-1:0]  pred_hist_q, pred_hist_d;

  logic [INDEX_LEN-1:0] rd_addr [NUM_PORTS];
  logic [CNT_BITS-1:0]  rd_data [NUM_PORTS];
  logic                 wr_en;
  logic [INDEX_LEN-1:0] wr_addr;
  logic [CNT_BITS-1:0]  wr_data;
  logic [CNT_BITS-1:0]  wr_rdata;
  logic [INDEX_LEN-1:0] upd_idx;
  logic [HIST_LEN-1:0]  ghr_shift;

  gshare_counter_array #(
    .INDEX_LEN (INDEX_LEN),
    .CNT_BITS  (CNT_BITS),
    .NUM_PORTS (NUM_PORTS)
  ) u_array (
    .clk      (clk),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rdata (wr_rdata)
  );

  // Per-lane read index hashed with the current (pre-shift) GHR
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      rd_addr[k] = INDEX_LEN'(hash_idx(HASH_W'(bus.IN_predAddr[k*INDEX_LEN +: INDEX_LEN]),
                                       HASH_W'(ghr_q)));
    end
  end

  assign upd_idx = INDEX_LEN'(hash_idx(HASH_W'(bus.IN_updAddr), HASH_W'(bus.IN_updHist)));

  // Speculative shift; a 1-bit history simply takes the new outcome
  if (HIST_LEN == 1) begin : g_hist1
    assign ghr_shift = bus.IN_specTaken;
  end else begin : g_histn
    assign ghr_shift = {ghr_q[HIST_LEN-2:0], bus.IN_specTaken};
  end

  // Next-state, write-port mux and output computation
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ghr_d        = ghr_q;
    ready_d      = ready_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_hist_d  = pred_hist_q;
    wr_en        = 1'b0;
    wr_addr      = ptr_q;
    wr_data      = INIT_VAL;

    if (rst) begin
      state_d      = ST_INIT;
      ptr_d        = '0;
      ghr_d        = '0;
      ready_d      = 1'b0;
      pred_taken_d = '0;
      pred_hist_d  = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          wr_en   = 1'b1;
          wr_addr = ptr_q;
          wr_data = INIT_VAL;
          ptr_d   = ptr_q + INDEX_LEN'(1);
          if (ptr_q == LAST_IDX) begin
            state_d = ST_READY;
            ready_d = 1'b1;
          end
        end
        ST_READY: begin
          pred_valid_d = bus.IN_predEn;
          if (bus.IN_predEn) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
              pred_taken_d[k] = rd_data[k][CNT_BITS-1];
            end
            pred_hist_d = ghr_q;
          end
          if (bus.IN_recoverEn) begin
            ghr_d = bus.IN_recoverHist;
          end else if (bus.IN_specEn) begin
            ghr_d = ghr_shift;
          end
          if (bus.IN_updEn) begin
            wr_en   = 1'b1;
            wr_addr = upd_idx;
            wr_data = CNT_BITS'(sat_update(SAT_W'(wr_rdata), bus.IN_updTaken, CNT_BITS));
          end
        end
        default: begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    ptr_q        <= ptr_d;
    ghr_q        <= ghr_d;
    ready_q      <= ready_d;
    pred_valid_q <= pred_valid_d;
    pred_taken_q <= pred_taken_d;
    pred_hist_q  <= pred_hist_d;
  end

  assign bus.OUT_ready     = ready_q;
  assign bus.OUT_predValid = pred_valid_q;
  assign bus.OUT_predTaken = pred_taken_q;
  assign bus.OUT_predHist  = pred_hist_q;

endmodule

// File: tb/tb_gshare_predictor_table.sv
// Directed bench for gshare_predictor_table with default parameters.
module tb_gshare_predictor_table;

  localparam int unsigned INDEX_LEN = 8;
  localparam int unsigned HIST_LEN  = 8;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned NVEC      = 26;

  logic clk;
  logic rst;

  gshare_predictor_table_if #(
    .INDEX_LEN (INDEX_LEN),
    .HIST_LEN  (HIST_LEN),
    .NUM_PORTS (NUM_PORTS)
  ) bus_if ();

  gshare_predictor_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pe;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       se;
    logic       st;
    logic       re;
    logic [7:0] rh;
    logic       ue;
    logic [7:0] ua;
    logic [7:0] uh;
    logic       ut;
    logic       ev;
    logic [1:0] et;
    logic [7:0] eh;
  } vec_t;

  vec_t vec [NVEC];
  int   checks;
  int   errors;
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus_if.IN_predEn      = 1'b0;
    bus_if.IN_predAddr    = '0;
    bus_if.IN_specEn      = 1'b0;
    bus_if.IN_specTaken   = 1'b0;
    bus_if.IN_recoverEn   = 1'b0;
    bus_if.IN_recoverHist = '0;
    bus_if.IN_updEn       = 1'b0;
    bus_if.IN_updAddr     = '0;
    bus_if.IN_updHist     = '0;
    bus_if.IN_updTaken    = 1'b0;
  endtask

  // Counts rising edges after rst release until OUT_ready is seen (bounded)
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus_if.OUT_ready) break;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;

    //  pe a0     a1     se st re rh     ue ua     uh     ut ev et     eh
    vec[0]  = '{1, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'h00};
    vec[1]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h05, 8'h00, 0, 0, 2'b11, 8'h00};
    vec[2]  = '{1, 8'h05, 8'h06, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'h00};
    vec[3]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 1, 0, 2'b10, 8'h00};
    vec[4]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 1, 0, 2'b10, 8'h00};
    vec[5]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 1, 0, 2'b10, 8'h00};
    vec[6]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 1, 0, 2'b10, 8'h00};
    vec[7]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 1, 0, 2'b10, 8'h00};
    vec[8]  = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 0, 0, 2'b10, 8'h00};
    vec[9]  = '{1, 8'h10, 8'h10, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'h00};
    vec[10] = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 0, 0, 2'b11, 8'h00};
    vec[11] = '{1, 8'h10, 8'h05, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b00, 8'h00};
    vec[12] = '{1, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'h00};
    vec[13] = '{1, 8'h04, 8'h07, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'h01};
    vec[14] = '{0, 8'h00, 8'h00, 0, 0, 1, 8'h3C, 0, 8'h00, 8'h00, 0, 0, 2'b10, 8'h01};
    vec[15] = '{1, 8'h3C, 8'h00, 1, 1, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'h3C};
    vec[16] = '{1, 8'hA0, 8'hA5, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'hA5};
    vec[17] = '{1, 8'hA0, 8'hA0, 0, 0, 0, 8'h00, 1, 8'h05, 8'h00, 1, 1, 2'b00, 8'hA5};
    vec[18] = '{1, 8'hA0, 8'hA0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'hA5};
    vec[19] = '{0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA0, 8'hA5, 0, 0, 2'b11, 8'hA5};
    vec[20] = '{1, 8'hA0, 8'hA5, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'hA5};
    vec[21] = '{0, 8'h00, 8'h00, 0, 0, 1, 8'h80, 0, 8'h00, 8'h00, 0, 0, 2'b10, 8'hA5};
    vec[22] = '{1, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b11, 8'h80};
    vec[23] = '{1, 8'h04, 8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'h01};
    vec[24] = '{0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 2'b10, 8'h01};
    vec[25] = '{1, 8'h07, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 2'b10, 8'h02};

    // Reset: outputs forced low
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.OUT_ready), 32'd0);
    chk("rst_valid", 32'(bus_if.OUT_predValid), 32'd0);
    chk("rst_taken", 32'(bus_if.OUT_predTaken), 32'd0);
    chk("rst_hist",  32'(bus_if.OUT_predHist), 32'd0);
    rst = 1'b0;

    // Init sweep length
    wait_ready(n);
    chk("sweep_len", 32'(n), 32'd256);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      bus_if.IN_predEn      = vec[i].pe;
      bus_if.IN_predAddr    = {vec[i].a1, vec[i].a0};
      bus_if.IN_specEn      = vec[i].se;
      bus_if.IN_specTaken   = vec[i].st;
      bus_if.IN_recoverEn   = vec[i].re;
      bus_if.IN_recoverHist = vec[i].rh;
      bus_if.IN_updEn       = vec[i].ue;
      bus_if.IN_updAddr     = vec[i].ua;
      bus_if.IN_updHist     = vec[i].uh;
      bus_if.IN_updTaken    = vec[i].ut;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(bus_if.OUT_predValid), 32'(vec[i].ev));
      chk($sformatf("v%0d_taken", i), 32'(bus_if.OUT_predTaken), 32'(vec[i].et));
      chk($sformatf("v%0d_hist", i),  32'(bus_if.OUT_predHist), 32'(vec[i].eh));
    end
    clear_inputs();

    // Reset from READY clears outputs and GHR
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_ready", 32'(bus_if.OUT_ready), 32'd0);
    chk("rst2_valid", 32'(bus_if.OUT_predValid), 32'd0);
    chk("rst2_taken", 32'(bus_if.OUT_predTaken), 32'd0);
    chk("rst2_hist",  32'(bus_if.OUT_predHist), 32'd0);
    rst = 1'b0;

    // Activity during the sweep is ignored; entry 0x33 would go not-taken
    bus_if.IN_predEn    = 1'b1;
    bus_if.IN_predAddr  = {8'h33, 8'h33};
    bus_if.IN_updEn     = 1'b1;
    bus_if.IN_updAddr   = 8'h33;
    bus_if.IN_updTaken  = 1'b0;
    bus_if.IN_specEn    = 1'b1;
    bus_if.IN_specTaken = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("init_valid", 32'(bus_if.OUT_predValid), 32'd0);
    chk("init_ready", 32'(bus_if.OUT_ready), 32'd0);

    // Restart the sweep mid-way
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    clear_inputs();
    chk("resweep_len", 32'(n), 32'd256);

    bus_if.IN_predEn   = 1'b1;
    bus_if.IN_predAddr = {8'h33, 8'h33};
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    chk("post_valid", 32'(bus_if.OUT_predValid), 32'd1);
    chk("post_taken", 32'(bus_if.OUT_predTaken), 32'd3);
    chk("post_hist",  32'(bus_if.OUT_predHist), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
